// File: rtl/machina_pkg.sv
// rtl/machina_pkg.sv - shared Q8.8 types, constants and the saturating narrow for associate-class blocks
package machina_pkg;

  localparam int FRAC = 8;

  typedef logic signed [15:0] res_t;
  typedef logic [31:0]        loss_t;

  typedef enum logic [1:0] {
    RES  = 2'd0,
    TGT  = 2'd1,
    ERR  = 2'd2,
    LOSS = 2'd3
  } state_t;

  // Clamp a 17-bit signed difference to the Q8.8 range [0x8000, 0x7fff].
  function automatic res_t sat16(input logic signed [16:0] x);
    if (x[16] != x[15]) return x[16] ? 16'sh8000 : 16'sh7fff;
    return x[15:0];
  endfunction

endpackage

// File: rtl/objective_if.sv
// rtl/objective_if.sv - valid/ready stream bundle used for the res, tgt, err and loss ports
interface objective_if #(parameter int W = 16) ();

  logic         valid;
  logic [W-1:0] data;
  logic         ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/saturate.sv
// rtl/saturate.sv - combinational narrowing with clamp, signed or unsigned, IN_W > OUT_W
module saturate #(
  parameter int IN_W   = 17,
  parameter int OUT_W  = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic [IN_W-1:0]  value,
  output logic [OUT_W-1:0] result
);

  generate
    if (SIGNED) begin : g_signed
      // Value fits when every bit from the output sign bit upward agrees.
      logic [IN_W-OUT_W:0] head;
      assign head = value[IN_W-1:OUT_W-1];
      always_comb begin
        if (head == '0 || head == '1) result = value[OUT_W-1:0];
        else if (value[IN_W-1])       result = {1'b1, {(OUT_W-1){1'b0}}};
        else                          result = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end else begin : g_unsigned
      logic [IN_W-OUT_W-1:0] head;
      assign head = value[IN_W-1:OUT_W];
      assign result = (|head) ? {OUT_W{1'b1}} : value[OUT_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/objective.sv
// rtl/objective.sv - training terminus: error delta toward associate and batched squared-error loss
module objective
  import machina_pkg::*;
#(
  parameter int BATCH = 4,
  parameter int SHIFT = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        train,
  objective_if.slave  res,
  objective_if.slave  tgt,
  objective_if.master err,
  objective_if.master loss
);

  localparam int CW = $clog2(BATCH + 1);

  state_t               state;
  res_t                 res_q;
  logic [CW-1:0]        count;
  loss_t                sum;

  logic signed [16:0]   tgt_x;
  logic signed [16:0]   res_x;
  logic signed [16:0]   diff;
  logic signed [16:0]   diff_sh;
  logic [15:0]          e_sat;
  logic [31:0]          e_ext;
  logic [31:0]          prod;
  logic [31:0]          sq;
  logic [32:0]          sum_wide;
  loss_t                sum_sat;

  // Readies decode the registered state only, so no input reaches them combinationally.
  assign res.ready = (state == RES);
  assign tgt.ready = (state == TGT);

  assign tgt_x   = {tgt.data[15], tgt.data};
  assign res_x   = {res_q[15], res_q};
  assign diff    = tgt_x - res_x;
  assign diff_sh = diff >>> SHIFT;

  saturate #(.IN_W(17), .OUT_W(16), .SIGNED(1'b1)) u_sat_err (
    .value  (diff_sh),
    .result (e_sat)
  );

  // e*e is never negative and at most 2^30, so the logical shift matches the arithmetic one.
  assign e_ext    = {{16{err.data[15]}}, err.data};
  assign prod     = e_ext * e_ext;
  assign sq       = prod >> FRAC;
  assign sum_wide = {1'b0, sum} + {1'b0, sq};

  saturate #(.IN_W(33), .OUT_W(32), .SIGNED(1'b0)) u_sat_sum (
    .value  (sum_wide),
    .result (sum_sat)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RES;
      res_q      <= '0;
      count      <= '0;
      sum        <= '0;
      err.valid  <= 1'b0;
      err.data   <= '0;
      loss.valid <= 1'b0;
      loss.data  <= '0;
    end else begin
      case (state)
        RES: begin
          if (res.valid && res.ready) begin
            res_q <= res.data;
            if (train) state <= TGT;
          end
        end
        TGT: begin
          if (tgt.valid && tgt.ready) begin
            err.data  <= e_sat;
            err.valid <= 1'b1;
            state     <= ERR;
          end
        end
        ERR: begin
          if (err.ready) begin
            err.valid <= 1'b0;
            if (count == CW'(BATCH - 1)) begin
              loss.data  <= sum_sat;
              loss.valid <= 1'b1;
              sum        <= '0;
              count      <= '0;
              state      <= LOSS;
            end else begin
              sum   <= sum_sat;
              count <= count + 1'b1;
              state <= RES;
            end
          end
        end
        LOSS: begin
          if (loss.ready) begin
            loss.valid <= 1'b0;
            state      <= RES;
          end
        end
        default: begin
          state      <= RES;
          err.valid  <= 1'b0;
          loss.valid <= 1'b0;
`ifndef SYNTHESIS
          $error("objective: illegal state encoding %0d", state);
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_objective.sv
// tb/tb_objective.sv - randomized throttled bench for objective against a queue-based reference model
module tb_objective;

  localparam int BATCH = 4;
  localparam int SHIFT = 0;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic train   = 1'b0;

  always #5 clock = ~clock;

  objective_if #(16) res_if ();
  objective_if #(16) tgt_if ();
  objective_if #(16) err_if ();
  objective_if #(32) loss_if ();

  objective #(.BATCH(BATCH), .SHIFT(SHIFT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .train   (train),
    .res     (res_if),
    .tgt     (tgt_if),
    .err     (err_if),
    .loss    (loss_if)
  );

  typedef struct {
    logic [15:0] r;
    logic [15:0] t;
    bit          tr;
  } sample_t;

  int checks = 0;
  int errors = 0;

  sample_t     pend_res[$];
  logic [15:0] pend_tgt[$];
  logic [15:0] exp_err[$];
  logic [31:0] exp_loss[$];
  longint      msum = 0;
  int          mcnt = 0;
  int          err_force = 0;
  int          loss_force = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int model_err(input logic [15:0] r, input logic [15:0] t);
    int ri, ti, d;
    ri = $signed(r);
    ti = $signed(t);
    d  = (ti - ri) >>> SHIFT;
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
    return d;
  endfunction

  task automatic add_sample(input logic [15:0] r, input logic [15:0] t, input bit tr);
    sample_t s;
    int      e;
    longint  sq;
    s.r = r; s.t = t; s.tr = tr;
    pend_res.push_back(s);
    if (tr) begin
      pend_tgt.push_back(t);
      e = model_err(r, t);
      exp_err.push_back(16'(e));
      sq   = (longint'(e) * longint'(e)) / 256;
      msum = msum + sq;
      if (msum > 64'h0000_0000_ffff_ffff) msum = 64'h0000_0000_ffff_ffff;
      mcnt++;
      if (mcnt == BATCH) begin
        exp_loss.push_back(32'(msum));
        msum = 0;
        mcnt = 0;
      end
    end
  endtask

  function automatic logic [15:0] rand16();
    case ($urandom_range(3))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      2:       return 16'($urandom_range(1023)) - 16'd512;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_err_valid", err_if.valid, 0);
    check("rst_loss_valid", loss_if.valid, 0);
    res_if.valid = 1'b0;
    tgt_if.valid = 1'b0;
    pend_res.delete(); pend_tgt.delete(); exp_err.delete(); exp_loss.delete();
    msum = 0; mcnt = 0; err_force = 0; loss_force = 0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_res_ready", res_if.ready, 1);
    check("rst_tgt_ready", tgt_if.ready, 0);
  endtask

  // abort_on: 0 run to completion, 1 reset once err is pending, 2 reset once loss is pending
  task automatic run(input int abort_on);
    bit          r_hold = 0, t_hold = 0, e_wait = 0, l_wait = 0;
    bit          lat_chk = 0, untrained = 0;
    logic [15:0] e_keep = '0;
    logic [31:0] l_keep = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clock);
      #1;
      if (lat_chk) begin
        check("err_latency", err_if.valid, 1);
        if (exp_err.size() > 0) check("err_latency_data", err_if.data, exp_err[0]);
        lat_chk = 0;
      end
      if (!r_hold) begin
        res_if.valid = 1'b0;
        if (pend_res.size() > 0 && $urandom_range(99) < 70) begin
          res_if.valid = 1'b1;
          res_if.data  = pend_res[0].r;
          train        = pend_res[0].tr;
          r_hold       = 1;
        end
      end
      if (!t_hold) begin
        tgt_if.valid = 1'b0;
        if (pend_tgt.size() > 0 && $urandom_range(99) < 70) begin
          tgt_if.valid = 1'b1;
          tgt_if.data  = pend_tgt[0];
          t_hold       = 1;
        end
      end
      err_if.ready  = (err_force > 0)  ? 1'b0 : ($urandom_range(99) < 70);
      loss_if.ready = (loss_force > 0) ? 1'b0 : ($urandom_range(99) < 70);

      @(negedge clock);
      check("ready_exclusive", res_if.ready & tgt_if.ready, 0);
      if (err_if.valid || loss_if.valid) begin
        check("res_ready_blocked", res_if.ready, 0);
        check("tgt_ready_blocked", tgt_if.ready, 0);
      end
      if (untrained) begin
        check("untrained_res_ready", res_if.ready, 1);
        check("untrained_tgt_ready", tgt_if.ready, 0);
        untrained = 0;
      end
      if (e_wait) begin
        check("err_hold_valid", err_if.valid, 1);
        check("err_hold_data", err_if.data, e_keep);
      end
      if (l_wait) begin
        check("loss_hold_valid", loss_if.valid, 1);
        check("loss_hold_data", loss_if.data, l_keep);
      end
      if ((abort_on == 1 && err_if.valid) || (abort_on == 2 && loss_if.valid)) begin
        do_reset();
        return;
      end
      if (err_if.valid && err_force > 0)  err_force--;
      if (loss_if.valid && loss_force > 0) loss_force--;

      if (res_if.valid && res_if.ready) begin
        untrained = !pend_res[0].tr;
        void'(pend_res.pop_front());
        r_hold = 0;
      end
      if (tgt_if.valid && tgt_if.ready) begin
        void'(pend_tgt.pop_front());
        t_hold  = 0;
        lat_chk = 1;
      end
      e_wait = 0;
      if (err_if.valid && err_if.ready) begin
        if (exp_err.size() == 0) check("err_unexpected", 1, 0);
        else check("err_data", err_if.data, exp_err.pop_front());
      end else if (err_if.valid) begin
        e_wait = 1;
        e_keep = err_if.data;
      end
      l_wait = 0;
      if (loss_if.valid && loss_if.ready) begin
        if (exp_loss.size() == 0) check("loss_unexpected", 1, 0);
        else check("loss_data", loss_if.data, exp_loss.pop_front());
      end else if (loss_if.valid) begin
        l_wait = 1;
        l_keep = loss_if.data;
      end
      if (pend_res.size() == 0 && pend_tgt.size() == 0 &&
          exp_err.size() == 0 && exp_loss.size() == 0) return;
    end
    check("phase_timeout", 1, 0);
  endtask

  initial begin
    logic [15:0] r;
    res_if.valid = 1'b0; res_if.data = '0;
    tgt_if.valid = 1'b0; tgt_if.data = '0;
    err_if.ready = 1'b0; loss_if.ready = 1'b0;

    repeat (2) @(posedge clock);
    #2;
    check("reset_err_valid", err_if.valid, 0);
    check("reset_err_data", err_if.data, 0);
    check("reset_loss_valid", loss_if.valid, 0);
    check("reset_loss_data", loss_if.data, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("release_res_ready", res_if.ready, 1);
    check("release_tgt_ready", tgt_if.ready, 0);

    add_sample(16'h0100, 16'h0300, 1'b1);
    add_sample(16'h8000, 16'h7fff, 1'b1);
    add_sample(16'h1234, 16'h0000, 1'b0);
    add_sample(16'h7fff, 16'h8000, 1'b1);
    add_sample(16'h0010, 16'h0020, 1'b1);
    run(0);

    err_force  = 5;
    loss_force = 3;
    for (int i = 0; i < 4; i++) begin
      r = 16'($urandom_range(4095)) - 16'd2048;
      add_sample(r, r + 16'h0100, 1'b1);
    end
    run(0);

    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < int'($urandom_range(12, 3)); i++)
        add_sample(rand16(), rand16(), $urandom_range(99) < 80);
      run(0);
    end

    add_sample(rand16(), rand16(), 1'b1);
    add_sample(rand16(), rand16(), 1'b1);
    run(1);

    for (int i = 0; i < BATCH; i++) add_sample(rand16(), rand16(), 1'b1);
    loss_force = 2;
    run(2);

    for (int i = 0; i < BATCH + 2; i++) add_sample(rand16(), rand16(), 1'b1);
    run(0);

    @(posedge clock);
    #1;
    res_if.valid = 1'b0;
    tgt_if.valid = 1'b0;
    repeat (3) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
